// File: rtl/control_unit_if.sv
// Control bundle between the hardwired sequencer and the single-bus datapath.
// CU_MEM_WAIT_EN adds the MemReady memory handshake.
interface control_unit_if;
  logic [31:0] IR;
`ifdef CU_MEM_WAIT_EN
  logic        MemReady;
`endif
  logic        PCout, Zhiout, Zlowout, MDRout, InPortout, BAout, Cout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONIn;
  logic        Gra, Grb, Grc, Rout, IncPC, Read, Write, Strobe;
  logic [3:0]  ALUop;
  logic        Run;
  logic        Illegal;
  logic [3:0]  State;

  modport master (
    input  IR,
`ifdef CU_MEM_WAIT_EN
    input  MemReady,
`endif
    output PCout, Zhiout, Zlowout, MDRout, InPortout, BAout, Cout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONIn,
    output Gra, Grb, Grc, Rout, IncPC, Read, Write, Strobe,
    output ALUop, Run, Illegal, State
  );

  modport slave (
    output IR,
`ifdef CU_MEM_WAIT_EN
    output MemReady,
`endif
    input  PCout, Zhiout, Zlowout, MDRout, InPortout, BAout, Cout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONIn,
    input  Gra, Grb, Grc, Rout, IncPC, Read, Write, Strobe,
    input  ALUop, Run, Illegal, State
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer (fetch T0-T2, decode/execute T3-T7) for the single-bus datapath.
// Define CU_MEM_WAIT_EN to stall T1, ld-T6 and st-T7 on the MemReady handshake.
module control_unit (
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [4:0] opcode_s;
  logic       mem_ready_s;
  logic       is_reg_alu_s;
  logic       is_imm_s;
  logic       is_ldi_s;
  logic       is_ld_s;
  logic       is_st_s;
  logic       is_halt_s;
  logic       is_illegal_s;
  logic [3:0] alu_sel_s;

  assign opcode_s = bus.IR[31:27];

`ifdef CU_MEM_WAIT_EN
  assign mem_ready_s = bus.MemReady;
`else
  assign mem_ready_s = 1'b1;
`endif

  // Opcode classification and ALU function select
  always_comb begin
    is_reg_alu_s = 1'b0;
    is_imm_s     = 1'b0;
    is_ldi_s     = 1'b0;
    is_ld_s      = 1'b0;
    is_st_s      = 1'b0;
    is_halt_s    = 1'b0;
    is_illegal_s = 1'b0;
    alu_sel_s    = ALU_ADD;
    case (opcode_s)
      OP_LD:   is_ld_s = 1'b1;
      OP_LDI:  is_ldi_s = 1'b1;
      OP_ST:   is_st_s = 1'b1;
      OP_ADD:  is_reg_alu_s = 1'b1;
      OP_SUB:  begin is_reg_alu_s = 1'b1; alu_sel_s = ALU_SUB; end
      OP_AND:  begin is_reg_alu_s = 1'b1; alu_sel_s = ALU_AND; end
      OP_OR:   begin is_reg_alu_s = 1'b1; alu_sel_s = ALU_OR;  end
      OP_ADDI: is_imm_s = 1'b1;
      OP_ANDI: begin is_imm_s = 1'b1; alu_sel_s = ALU_AND; end
      OP_ORI:  begin is_imm_s = 1'b1; alu_sel_s = ALU_OR;  end
      OP_NOP:  is_illegal_s = 1'b0;
      OP_HALT: is_halt_s = 1'b1;
      default: is_illegal_s = 1'b1;
    endcase
  end

  // State register; Clear aborts any instruction in flight
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state sequencing, including memory stalls
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RESET: state_nxt_s = S_T0;
      S_T0:    state_nxt_s = S_T1;
      S_T1:    state_nxt_s = mem_ready_s ? S_T2 : S_T1;
      S_T2:    state_nxt_s = S_T3;
      S_T3: begin
        if (is_halt_s) begin
          state_nxt_s = S_HALT;
        end else if (is_reg_alu_s || is_imm_s || is_ldi_s || is_ld_s || is_st_s) begin
          state_nxt_s = S_T4;
        end else begin
          state_nxt_s = S_T0;
        end
      end
      S_T4:    state_nxt_s = S_T5;
      S_T5:    state_nxt_s = (is_ld_s || is_st_s) ? S_T6 : S_T0;
      S_T6:    state_nxt_s = (is_ld_s && !mem_ready_s) ? S_T6 : S_T7;
      S_T7:    state_nxt_s = (is_st_s && !mem_ready_s) ? S_T7 : S_T0;
      S_HALT:  state_nxt_s = S_HALT;
      default: state_nxt_s = S_RESET;
    endcase
  end

  // Moore output decode from state and opcode
  always_comb begin
    bus.PCout     = 1'b0;
    bus.Zhiout    = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.MDRout    = 1'b0;
    bus.InPortout = 1'b0;
    bus.BAout     = 1'b0;
    bus.Cout      = 1'b0;
    bus.MARin     = 1'b0;
    bus.Zin       = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.OutPortin = 1'b0;
    bus.Rin       = 1'b0;
    bus.CONIn     = 1'b0;
    bus.Gra       = 1'b0;
    bus.Grb       = 1'b0;
    bus.Grc       = 1'b0;
    bus.Rout      = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.Strobe    = 1'b0;
    bus.ALUop     = ALU_ADD;
    bus.Illegal   = 1'b0;
    bus.Run       = (state_r != S_RESET) && (state_r != S_HALT);
    case (state_r)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        if (is_reg_alu_s || is_imm_s) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (is_ldi_s || is_ld_s || is_st_s) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else begin
          bus.Illegal = is_illegal_s;
        end
      end
      S_T4: begin
        bus.Zin   = 1'b1;
        bus.ALUop = alu_sel_s;
        if (is_reg_alu_s) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1;
        end else begin
          bus.Cout = 1'b1;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_ld_s || is_st_s) begin
          bus.MARin = 1'b1;
        end else begin
          bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      S_T6: begin
        bus.MDRin = 1'b1;
        if (is_ld_s) begin
          bus.Read = 1'b1;
        end else begin
          bus.Gra = 1'b1; bus.Rout = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld_s) begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end else begin
          bus.Write = 1'b1;
        end
      end
      default: bus.Run = bus.Run;
    endcase
  end

  assign bus.State = state_r;

endmodule
